// File: rtl/mc_maindec_pkg.sv
// Shared codes for the multicycle MIPS main decoder: opcodes, FSM states,
// ALU/PC select encodings and the control word driven into the datapath.
package mc_maindec_pkg;

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control word decode. Only FETCH strobes look at
// mem_ready; MEMWR holds memwrite high for as long as the state persists.
module mc_outdec
  import mc_maindec_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic               mem_ready_i,
  output ctrl_t              ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.alusrcb = ALUSRCB_FOUR;
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      S_DECODE:  ctrl_o.alusrcb = ALUSRCB_IMMSH;
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD:   ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_IMM;
      end
      S_ADDIWB:  ctrl_o.regwrite = 1'b1;
      S_JEX: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      // unreachable codes look like a stalled fetch
      default:   ctrl_o.alusrcb = ALUSRCB_FOUR;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main decoder: state register plus next-state logic; the
// control word comes from mc_outdec and write strobes are masked in reset.
module mc_maindec
  import mc_maindec_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               regdst,
  output logic               memtoreg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  mc_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign pcwrite    = ctrl.pcwrite  & reset;
  assign branch     = ctrl.branch   & reset;
  assign irwrite    = ctrl.irwrite  & reset;
  assign memwrite   = ctrl.memwrite & reset;
  assign regwrite   = ctrl.regwrite & reset;
  assign iord       = ctrl.iord;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign aluop      = ctrl.aluop;
  assign pcsrc      = ctrl.pcsrc;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign illegal_op = reset & (state_q == S_DECODE) & ~op_legal(op);
  assign state      = state_q;

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
- Multicycle main-decoder FSM for the MIPS core.
- Sits directly upstream of the ALU function decoder and drives its 2-bit aluop: 00 = add, 01 = sub, 10 = decode funct.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and emits datapath mux selects and write strobes.
- Handshakes with instruction/data memory through mem_ready.

Parameters:
- None. State encoding is a package constant, 4 bits wide.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset. 0 = reset.
- op  in  6  opcode field of the instruction register.
- mem_ready  in  1  memory accepted the current fetch, read or write this cycle.
- pcwrite  out  1  unconditional PC write strobe.
- branch  out  1  conditional PC write; the datapath ANDs it with zero.
- irwrite  out  1  instruction-register load strobe.
- memwrite  out  1  data memory write request.
- regwrite  out  1  register file write strobe.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2.
- aluop  out  2  to the ALU decoder.
- pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- regdst  out  1  write register select: 0 = rt, 1 = rd.
- memtoreg  out  1  write data select: 0 = ALUOut, 1 = memory data.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  out  4  current state, for debug and bench observation.

Behaviour:
- Moore FSM. Outputs are decoded combinationally from state; only the strobes below also depend on mem_ready.
- Any output not listed for a state is 0.
- Reset:
  - reset==0 at a rising edge: next state = FETCH, regardless of the current state. This includes mid-MEMWR and mid-fetch.
  - While reset==0: pcwrite, irwrite, memwrite, regwrite, branch and illegal_op are forced to 0.
  - After reset: state = FETCH, aluop = 00, alusrcb = 01, all other outputs 0.
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- States and transitions:
  - FETCH (0): iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite = pcwrite = mem_ready. mem_ready ? DECODE : FETCH.
  - DECODE (1): alusrca=0, alusrcb=11, aluop=00. LW/SW -> MEMADR, RTYPE -> RTYPEEX, BEQ -> BEQEX, ADDI -> ADDIEX, J -> JEX. Any other opcode -> FETCH with illegal_op=1 for this cycle.
  - MEMADR (2): alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD, SW -> MEMWR. op is held stable by the IR.
  - MEMRD (3): iord=1. mem_ready ? MEMWB : MEMRD.
  - MEMWB (4): regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR (5): iord=1, memwrite=1, held until mem_ready. mem_ready ? FETCH : MEMWR.
  - RTYPEEX (6): alusrca=1, alusrcb=00, aluop=10 -> RTYPEWB.
  - RTYPEWB (7): regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BEQEX (8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
  - ADDIEX (9): alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
  - ADDIWB (10): regdst=0, regwrite=1 -> FETCH.
  - JEX (11): pcsrc=10, pcwrite=1 -> FETCH.
  - Codes 12-15: unreachable. Treat as FETCH outputs with strobes 0; next state = FETCH.
- Latency in cycles, mem_ready always 1: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each memory wait cycle adds 1. There is no timeout.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.

Decomposition:
- Shared package holds:
  - opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J);
  - state codes S_FETCH..S_JEX;
  - aluop codes ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10;
  - alusrcb and pcsrc select codes.
- The ALU decoder imports the same aluop codes.
- Optional sub-module mc_outdec: purely combinational state -> control-word decode. It keeps the FSM register plus next-state logic in mc_maindec.

Test Plan:
- Reset: hold reset=0 for 3 cycles from a random state, including MEMWR with memwrite high. Required: state=0 after the first edge, and all strobes 0 throughout.
- LW, mem_ready=1: op=100011. Required: state sequence 0,1,2,3,4,0. aluop=00 in states 1 and 2. regwrite=1, memtoreg=1, regdst=0 only in state 4.
- RTYPE: op=000000. Required: sequence 0,1,6,7,0. aluop=10 only in state 6. regwrite=1, regdst=1 in state 7.
- BEQ and J:
  - op=000100: sequence 0,1,8,0, with aluop=01, branch=1, pcsrc=01 in state 8.
  - op=000010: sequence 0,1,11,0, with pcwrite=1, pcsrc=10.
- Memory stall:
  - SW with mem_ready low for 3 cycles in MEMWR. Required: memwrite=1 for 4 cycles, then state 0.
  - Fetch with mem_ready low for 2 cycles. Required: irwrite and pcwrite stay 0 until mem_ready=1.
- Illegal opcode: op=111111. Required: illegal_op=1 for exactly one cycle in state 1, then state 0, with no write strobes.
